// File: rtl/alu_op_scheduler_if.sv
// -----------------------------------------------------------------------------
// alu_op_scheduler_if
//   Bundles the request ports (CPU and user/debug), the ALU register-block
//   drive/readback bus and the result/status outputs of alu_op_scheduler.
//
//   slave  : the scheduler side (receives requests and BR/MR, drives the rest)
//   master : the requesters plus the ALU register block
//
//   Signals
//     i_cpu_req/op/p/q, o_cpu_ack : CPU request, opcode, operands, ack pulse
//     i_usr_req/op/p/q, o_usr_ack : user/debug port, same meaning
//     o_alu_p/q/op/en             : ALU operands, opcode, one-cycle enable
//     o_c9, o_c10                 : BR / MR bus read strobes
//     i_br, i_mr                  : BR / MR bus values (zero when not strobed)
//     o_res_lo/hi/valid/owner     : last result, completion pulse, requester
//     o_busy                      : scheduler not in IDLE
// -----------------------------------------------------------------------------
interface alu_op_scheduler_if;
    logic        i_cpu_req;
    logic [2:0]  i_cpu_op;
    logic [15:0] i_cpu_p;
    logic [15:0] i_cpu_q;
    logic        o_cpu_ack;

    logic        i_usr_req;
    logic [2:0]  i_usr_op;
    logic [15:0] i_usr_p;
    logic [15:0] i_usr_q;
    logic        o_usr_ack;

    logic [15:0] o_alu_p;
    logic [15:0] o_alu_q;
    logic [2:0]  o_alu_op;
    logic        o_alu_en;
    logic        o_c9;
    logic        o_c10;
    logic [15:0] i_br;
    logic [15:0] i_mr;

    logic [15:0] o_res_lo;
    logic [15:0] o_res_hi;
    logic        o_res_valid;
    logic        o_res_owner;
    logic        o_busy;

    modport slave (
        input  i_cpu_req, i_cpu_op, i_cpu_p, i_cpu_q,
        input  i_usr_req, i_usr_op, i_usr_p, i_usr_q,
        input  i_br, i_mr,
        output o_cpu_ack, o_usr_ack,
        output o_alu_p, o_alu_q, o_alu_op, o_alu_en, o_c9, o_c10,
        output o_res_lo, o_res_hi, o_res_valid, o_res_owner, o_busy
    );

    modport master (
        output i_cpu_req, i_cpu_op, i_cpu_p, i_cpu_q,
        output i_usr_req, i_usr_op, i_usr_p, i_usr_q,
        output i_br, i_mr,
        input  o_cpu_ack, o_usr_ack,
        input  o_alu_p, o_alu_q, o_alu_op, o_alu_en, o_c9, o_c10,
        input  o_res_lo, o_res_hi, o_res_valid, o_res_owner, o_busy
    );
endinterface

// File: rtl/alu_op_scheduler.sv
// -----------------------------------------------------------------------------
// alu_op_scheduler
//   Two-port arbiter and sequencer in front of the ALU register block.
//   One request is granted at a time; the ALU is enabled for one cycle, then
//   BR (and MR for MPY) are read back via the C9/C10 strobes and the result is
//   returned to the winning port with a one-cycle acknowledge.
//
//   Ports
//     i_clk  : clock, all state on the rising edge
//     i_rst  : synchronous active-high reset (aborts any op in flight)
//     bus    : alu_op_scheduler_if.slave (requests, ALU bus, results)
//
//   Parameter
//     STARVE_LIMIT : consecutive CPU grants tolerated while the user port
//                    waits; the next grant then goes to the user (1..15)
// -----------------------------------------------------------------------------
module alu_op_scheduler #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    alu_op_scheduler_if.slave  bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_EXEC  = 3'd1;
    localparam logic [2:0] S_WB_LO = 3'd2;
    localparam logic [2:0] S_WB_HI = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [2:0] OP_MPY  = 3'b010;
    localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);

    logic [2:0]  state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] p_q, p_d;
    logic [15:0] q_q, q_d;
    logic        owner_q, owner_d;
    logic [3:0]  starve_q, starve_d;
    logic [15:0] res_lo_q, res_lo_d;
    logic [15:0] res_hi_q, res_hi_d;
    logic        grant_usr;

    // User wins when it is the only requester, or when the CPU has been
    // granted STARVE_LIMIT times in a row while the user was waiting.
    assign grant_usr = bus.i_usr_req && (!bus.i_cpu_req || (starve_q == LIMIT));

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        p_d      = p_q;
        q_d      = q_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;

        case (state_q)
            S_IDLE: begin
                if (bus.i_cpu_req || bus.i_usr_req) begin
                    state_d = S_EXEC;
                    owner_d = grant_usr;
                    op_d    = grant_usr ? bus.i_usr_op : bus.i_cpu_op;
                    p_d     = grant_usr ? bus.i_usr_p  : bus.i_cpu_p;
                    q_d     = grant_usr ? bus.i_usr_q  : bus.i_cpu_q;
                end
            end
            S_EXEC:  state_d = S_WB_LO;
            S_WB_LO: begin
                res_lo_d = bus.i_br;
                if (op_q == OP_MPY) begin
                    state_d = S_WB_HI;
                end else begin
                    res_hi_d = 16'h0;
                    state_d  = S_DONE;
                end
            end
            S_WB_HI: begin
                res_hi_d = bus.i_mr;
                state_d  = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Starvation count only means something while the user is waiting.
        if (!bus.i_usr_req) begin
            starve_d = 4'd0;
        end else if (state_q == S_IDLE) begin
            if (grant_usr) begin
                starve_d = 4'd0;
            end else if (bus.i_cpu_req) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            op_q     <= 3'd0;
            p_q      <= 16'h0;
            q_q      <= 16'h0;
            owner_q  <= 1'b0;
            starve_q <= 4'd0;
            res_lo_q <= 16'h0;
            res_hi_q <= 16'h0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            p_q      <= p_d;
            q_q      <= q_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
        end
    end

    // ALU drive is gated so the operand/opcode bus reads zero outside EXEC.
    assign bus.o_alu_en    = (state_q == S_EXEC);
    assign bus.o_alu_op    = bus.o_alu_en ? op_q : 3'd0;
    assign bus.o_alu_p     = bus.o_alu_en ? p_q  : 16'h0;
    assign bus.o_alu_q     = bus.o_alu_en ? q_q  : 16'h0;
    assign bus.o_c9        = (state_q == S_WB_LO);
    assign bus.o_c10       = (state_q == S_WB_HI);
    assign bus.o_res_valid = (state_q == S_DONE);
    assign bus.o_cpu_ack   = bus.o_res_valid && !owner_q;
    assign bus.o_usr_ack   = bus.o_res_valid &&  owner_q;
    assign bus.o_res_owner = owner_q;
    assign bus.o_res_lo    = res_lo_q;
    assign bus.o_res_hi    = res_hi_q;
    assign bus.o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_op_scheduler.sv
// -----------------------------------------------------------------------------
// tb_alu_op_scheduler
//   Bench for alu_op_scheduler: models the ALU register block, drives both
//   request ports, and checks results through per-port scoreboards filled at
//   issue time and drained by an independent monitor.
// -----------------------------------------------------------------------------
module tb_alu_op_scheduler;
    localparam int STARVE_LIMIT = 4;

    logic clk = 1'b0;
    logic rst;

    alu_op_scheduler_if bus();

    alu_op_scheduler #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] lo;
        logic [15:0] hi;
        bit          mpy;
    } exp_t;

    exp_t cpu_sb[$];
    exp_t usr_sb[$];
    bit   own_sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference ALU: {hi, lo}; hi is only meaningful for MPY.
    function automatic logic [31:0] alu_fn(logic [2:0] op, logic [15:0] p, logic [15:0] q);
        case (op)
            3'd0:    return {16'h0, 16'(p + q)};
            3'd1:    return {16'h0, 16'(p - q)};
            3'd2:    return 32'(p) * 32'(q);
            3'd3:    return {16'h0, p & q};
            3'd4:    return {16'h0, p | q};
            3'd5:    return {16'h0, p ^ q};
            3'd6:    return {16'h0, p >> q[3:0]};
            default: return {16'h0, p << q[3:0]};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // ALU register block model: latches on enable, presents BR/MR on strobe.
    logic [31:0] alu_r = 32'h0;
    always @(posedge clk) if (bus.o_alu_en) alu_r <= alu_fn(bus.o_alu_op, bus.o_alu_p, bus.o_alu_q);
    assign bus.i_br = bus.o_c9  ? alu_r[15:0]  : 16'h0;
    assign bus.i_mr = bus.o_c10 ? alu_r[31:16] : 16'h0;

    function automatic logic [74:0] all_outs();
        return {bus.o_cpu_ack, bus.o_usr_ack, bus.o_alu_p, bus.o_alu_q, bus.o_alu_op,
                bus.o_alu_en, bus.o_c9, bus.o_c10, bus.o_res_lo, bus.o_res_hi,
                bus.o_res_valid, bus.o_res_owner, bus.o_busy};
    endfunction

    function automatic bit port_ack(bit usr);
        return usr ? bus.o_usr_ack : bus.o_cpu_ack;
    endfunction

    task automatic sb_push(input bit usr, input logic [2:0] op, input logic [15:0] p, input logic [15:0] q);
        exp_t e;
        logic [31:0] r;
        r     = alu_fn(op, p, q);
        e.lo  = r[15:0];
        e.hi  = r[31:16];
        e.mpy = (op == 3'd2);
        if (usr) usr_sb.push_back(e);
        else     cpu_sb.push_back(e);
    endtask

    task automatic set_req(input bit usr, input logic r, input logic [2:0] op,
                           input logic [15:0] p, input logic [15:0] q);
        if (usr) begin
            bus.i_usr_req = r; bus.i_usr_op = op; bus.i_usr_p = p; bus.i_usr_q = q;
        end else begin
            bus.i_cpu_req = r; bus.i_cpu_op = op; bus.i_cpu_p = p; bus.i_cpu_q = q;
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (bus.o_busy && t < 50);
        if (bus.o_busy) fail_now("wait_idle_timeout");
    endtask

    // Monitor: drains the scoreboards whenever a result is presented.
    int   en_cnt, c9_cnt, c10_cnt;
    exp_t mon_e;
    bit   mon_own;
    initial begin
        en_cnt = 0; c9_cnt = 0; c10_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                en_cnt = 0; c9_cnt = 0; c10_cnt = 0;
            end else begin
                if (bus.o_alu_en) en_cnt++;
                if (bus.o_c9)     c9_cnt++;
                if (bus.o_c10)    c10_cnt++;
                if (bus.o_alu_en || bus.o_c9 || bus.o_c10)
                    chk("strobe_exclusive", 80'(int'(bus.o_alu_en) + int'(bus.o_c9) + int'(bus.o_c10)), 80'(1));
                if (!bus.o_alu_en)
                    chk("alu_bus_idle_zero", 80'({bus.o_alu_op, bus.o_alu_p, bus.o_alu_q}), 80'(0));
                if (bus.o_cpu_ack || bus.o_usr_ack)
                    chk("ack_with_valid", 80'(bus.o_res_valid), 80'(1));
                if (bus.o_res_valid) begin
                    mon_own = bus.o_res_owner;
                    chk("cpu_ack_owner", 80'(bus.o_cpu_ack), 80'(!mon_own));
                    chk("usr_ack_owner", 80'(bus.o_usr_ack), 80'(mon_own));
                    if ((mon_own && usr_sb.size() == 0) || (!mon_own && cpu_sb.size() == 0)) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_result: owner %0d lo %h hi %h, none outstanding",
                                 mon_own, bus.o_res_lo, bus.o_res_hi);
                    end else begin
                        mon_e = mon_own ? usr_sb.pop_front() : cpu_sb.pop_front();
                        chk("res_lo",        80'(bus.o_res_lo), 80'(mon_e.lo));
                        chk("res_hi",        80'(bus.o_res_hi), 80'(mon_e.hi));
                        chk("alu_en_pulses", 80'(en_cnt),       80'(1));
                        chk("c9_pulses",     80'(c9_cnt),       80'(1));
                        chk("c10_pulses",    80'(c10_cnt),      80'(mon_e.mpy));
                    end
                    if (own_sb.size() > 0) chk("grant_order", 80'(mon_own), 80'(own_sb.pop_front()));
                    en_cnt = 0; c9_cnt = 0; c10_cnt = 0;
                end
            end
        end
    end

    // Single directed op with cycle-exact strobe/ack checks; cycle 1 = EXEC.
    task automatic directed_op(input bit usr, input logic [2:0] op, input logic [15:0] p,
                               input logic [15:0] q, input logic [15:0] exp_lo,
                               input logic [15:0] exp_hi, input bit garble);
        bit mpy;
        int ack_cyc;
        wait_idle();
        mpy     = (op == 3'd2);
        ack_cyc = mpy ? 4 : 3;
        sb_push(usr, op, p, q);
        set_req(usr, 1'b1, op, p, q);
        for (int k = 1; k <= ack_cyc; k++) begin
            @(negedge clk);
            chk("dir_alu_en", 80'(bus.o_alu_en), 80'(k == 1));
            chk("dir_c9",     80'(bus.o_c9),     80'(k == 2));
            chk("dir_c10",    80'(bus.o_c10),    80'(mpy && k == 3));
            chk("dir_ack",    80'(port_ack(usr)), 80'(k == ack_cyc));
            if (k == 1) begin
                chk("dir_alu_operands", 80'({bus.o_alu_op, bus.o_alu_p, bus.o_alu_q}), 80'({op, p, q}));
                if (garble) set_req(usr, 1'b1, ~op, ~p, ~q);
            end
            if (k == ack_cyc) begin
                chk("dir_res_lo",    80'(bus.o_res_lo),    80'(exp_lo));
                chk("dir_res_hi",    80'(bus.o_res_hi),    80'(exp_hi));
                chk("dir_res_owner", 80'(bus.o_res_owner), 80'(usr));
                set_req(usr, 1'b0, 3'd0, 16'h0, 16'h0);
            end
        end
    endtask

    // Randomised requester: back-to-back when the drawn gap is zero.
    task automatic drive_port(input bit usr, input int n, input int maxgap);
        logic [2:0]  op;
        logic [15:0] p, q;
        int          gap;
        bit          acked;
        for (int i = 0; i < n; i++) begin
            op = 3'($urandom_range(0, 7));
            p  = 16'($urandom);
            q  = 16'($urandom);
            sb_push(usr, op, p, q);
            set_req(usr, 1'b1, op, p, q);
            acked = 1'b0;
            for (int t = 0; t < 300 && !acked; t++) begin
                @(negedge clk);
                acked = port_ack(usr);
            end
            if (!acked) begin
                fail_now(usr ? "usr_ack_timeout" : "cpu_ack_timeout");
                set_req(usr, 1'b0, 3'd0, 16'h0, 16'h0);
                return;
            end
            gap = int'($urandom_range(0, maxgap));
            if (gap > 0 || i == n - 1) begin
                set_req(usr, 1'b0, 3'd0, 16'h0, 16'h0);
                repeat (gap) @(negedge clk);
            end
        end
    endtask

    // Abstract arbitration model for two ports requesting without pause.
    task automatic build_order(input int c, input int u);
        int cs;
        cs = 0;
        while (c > 0 || u > 0) begin
            if (u > 0 && (c == 0 || cs == STARVE_LIMIT)) begin
                own_sb.push_back(1'b1); u--; cs = 0;
            end else begin
                own_sb.push_back(1'b0); c--; cs = (u > 0) ? cs + 1 : 0;
            end
        end
    endtask

    initial begin
        int en_cyc[$];
        int acks;
        int resv;

        rst = 1'b1;
        set_req(1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
        set_req(1'b1, 1'b0, 3'd0, 16'h0, 16'h0);
        repeat (3) @(negedge clk);
        chk("reset_outputs", 80'(all_outs()), 80'(0));
        rst = 1'b0;

        directed_op(1'b0, 3'd0, 16'h0003, 16'h0004, 16'h0007, 16'h0000, 1'b0);
        directed_op(1'b1, 3'd2, 16'h4000, 16'h0004, 16'h0000, 16'h0001, 1'b0);
        directed_op(1'b0, 3'd5, 16'h1234, 16'h00FF, 16'h12CB, 16'h0000, 1'b1);

        // Both ports requesting continuously: CPU x4 then USER, repeated.
        wait_idle();
        build_order(12, 3);
        fork
            drive_port(1'b0, 12, 0);
            drive_port(1'b1, 3, 0);
        join
        chk("grant_order_drained", 80'(own_sb.size()), 80'(0));

        // Back-to-back CPU SUB then AND, request held across the first ack.
        wait_idle();
        sb_push(1'b0, 3'd1, 16'h0010, 16'h0003);
        sb_push(1'b0, 3'd3, 16'h00F0, 16'h0F3C);
        set_req(1'b0, 1'b1, 3'd1, 16'h0010, 16'h0003);
        acks = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.o_alu_en) en_cyc.push_back(k);
            if (bus.o_cpu_ack) begin
                acks++;
                if (acks == 1) begin
                    chk("b2b_sub_res", 80'(bus.o_res_lo), 80'(16'h000D));
                    set_req(1'b0, 1'b1, 3'd3, 16'h00F0, 16'h0F3C);
                end else begin
                    chk("b2b_and_res", 80'(bus.o_res_lo), 80'(16'h0030));
                    set_req(1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
                end
            end
        end
        set_req(1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
        chk("b2b_ack_count", 80'(acks), 80'(2));
        chk("b2b_en_count", 80'(en_cyc.size()), 80'(2));
        if (en_cyc.size() == 2) chk("b2b_en_spacing", 80'(en_cyc[1] - en_cyc[0]), 80'(4));

        // Random traffic on both ports.
        wait_idle();
        fork
            drive_port(1'b0, 20, 3);
            drive_port(1'b1, 20, 3);
        join

        // Reset during WB_LO of a user MPY: abort, no ack, results cleared.
        wait_idle();
        set_req(1'b1, 1'b1, 3'd2, 16'h1111, 16'h0003);
        @(negedge clk);
        @(negedge clk);
        chk("rst_test_in_wb_lo", 80'(bus.o_c9), 80'(1));
        rst = 1'b1;
        set_req(1'b1, 1'b0, 3'd0, 16'h0, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_abort_outputs", 80'(all_outs()), 80'(0));
        acks = 0;
        resv = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.o_cpu_ack || bus.o_usr_ack) acks++;
            if (bus.o_res_valid) resv++;
        end
        chk("rst_no_ack", 80'(acks), 80'(0));
        chk("rst_no_valid", 80'(resv), 80'(0));

        chk("cpu_sb_drained", 80'(cpu_sb.size()), 80'(0));
        chk("usr_sb_drained", 80'(usr_sb.size()), 80'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
